// File: rtl/xor_decrypter.sv
// Stream XOR decrypter: valid/ready in and out, session FSM, byte counter and completion LED.
// Optional rolling-key mode is built when XOR_DEC_ROLLING_KEY_EN is defined.
module xor_decrypter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               start_reset_n,
    input  logic [2:0]         shift,
    input  logic [7:0]         key,
    input  logic               xor_enable,
    input  logic               improved_decrypt_enable,
    input  logic [7:0]         din,
    input  logic               din_valid,
    input  logic               din_last,
    output logic               din_ready,
    output logic [7:0]         dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic [COUNT_W-1:0] byte_count,
    output logic               led_complete
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t     state;
    logic [7:0] key_r;
    logic       in_hs;
    logic       out_hs;

    function automatic logic [7:0] rotl8(input logic [7:0] k, input logic [2:0] s);
        logic [15:0] t;
        t = {k, k} << s;
        return t[15:8];
    endfunction

`ifdef XOR_DEC_ROLLING_KEY_EN
    logic rolling_r;
`else
    logic unused_improved;
    assign unused_improved = improved_decrypt_enable;
`endif

    // Ready is combinational on dout_ready so a full output register can hand off every cycle.
    assign din_ready = (state == RUN) && (!dout_valid || dout_ready);
    assign in_hs     = din_valid && din_ready;
    assign out_hs    = dout_valid && dout_ready;

    // NOTE: all state below updates with non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (!start_reset_n) begin
            state        <= IDLE;
            key_r        <= 8'h00;
            dout         <= 8'h00;
            dout_valid   <= 1'b0;
            dout_last    <= 1'b0;
            byte_count   <= '0;
            led_complete <= 1'b0;
`ifdef XOR_DEC_ROLLING_KEY_EN
            rolling_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (xor_enable) begin
                        key_r        <= rotl8(key, shift);
                        byte_count   <= '0;
                        led_complete <= 1'b0;
`ifdef XOR_DEC_ROLLING_KEY_EN
                        rolling_r    <= improved_decrypt_enable;
`endif
                        state        <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (!xor_enable) begin
                        // Abort: pending output byte is dropped, counter keeps its value.
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        if (out_hs)
                            byte_count <= byte_count + 1'b1;
                        if (in_hs) begin
                            dout       <= din ^ key_r;
                            dout_valid <= 1'b1;
                            dout_last  <= din_last;
                            if (din_last)
                                state <= DRAIN;
`ifdef XOR_DEC_ROLLING_KEY_EN
                            if (rolling_r)
                                key_r <= {key_r[6:0], key_r[7]};
`endif
                        end else if (out_hs) begin
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                        end
                        if (state == DRAIN && out_hs && dout_last) begin
                            led_complete <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!xor_enable)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_decrypter.sv
// Directed self-checking bench for xor_decrypter; expected values are hand-computed.
module tb_xor_decrypter;

    localparam int COUNT_W = 16;

    logic               clk = 1'b0;
    logic               start_reset_n;
    logic [2:0]         shift;
    logic [7:0]         key;
    logic               xor_enable;
    logic               improved_decrypt_enable;
    logic [7:0]         din;
    logic               din_valid;
    logic               din_last;
    logic               din_ready;
    logic [7:0]         dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               dout_last;
    logic [COUNT_W-1:0] byte_count;
    logic               led_complete;

    int checks   = 0;
    int failures = 0;

    xor_decrypter #(.COUNT_W(COUNT_W)) dut (
        .clk                     (clk),
        .start_reset_n           (start_reset_n),
        .shift                   (shift),
        .key                     (key),
        .xor_enable              (xor_enable),
        .improved_decrypt_enable (improved_decrypt_enable),
        .din                     (din),
        .din_valid               (din_valid),
        .din_last                (din_last),
        .din_ready               (din_ready),
        .dout                    (dout),
        .dout_valid              (dout_valid),
        .dout_ready              (dout_ready),
        .dout_last               (dout_last),
        .byte_count              (byte_count),
        .led_complete            (led_complete)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] s2_in  [4];
    logic [7:0] s2_exp [4];
    logic [7:0] s6_in  [3];
    logic [7:0] s6_exp [3];

    initial begin
        s2_in  = '{8'h3C, 8'h3D, 8'hFF, 8'h00};
        s2_exp = '{8'h00, 8'h01, 8'hC3, 8'h3C};
        s6_in  = '{8'h01, 8'h02, 8'h04};
`ifdef XOR_DEC_ROLLING_KEY_EN
        s6_exp = '{8'h00, 8'h00, 8'h00};
`else
        s6_exp = '{8'h00, 8'h03, 8'h05};
`endif
        start_reset_n = 1'b0;
        shift = 3'd0; key = 8'h00; xor_enable = 1'b0; improved_decrypt_enable = 1'b0;
        din = 8'h00; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b1;
        tick();
        tick();
        check("rst_dout", dout, 8'h00);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_din_ready", din_ready, 1'b0);
        check("rst_byte_count", byte_count, 0);
        check("rst_led", led_complete, 1'b0);
        start_reset_n = 1'b1;

        // 1. Basic decrypt, key 0xA5 rotl 3 = 0x2D
        key = 8'hA5; shift = 3'd3; xor_enable = 1'b1;
        din = 8'h6D; din_valid = 1'b1; din_last = 1'b1;
        #1 check("t1_idle_no_ready", din_ready, 1'b0);
        tick();
        check("t1_run_ready", din_ready, 1'b1);
        tick();
        din_valid = 1'b0; din_last = 1'b0;
        check("t1_dout", dout, 8'h40);
        check("t1_dout_valid", dout_valid, 1'b1);
        check("t1_dout_last", dout_last, 1'b1);
        tick();
        check("t1_valid_clear", dout_valid, 1'b0);
        check("t1_byte_count", byte_count, 1);
        check("t1_led", led_complete, 1'b1);
        check("t1_done_no_ready", din_ready, 1'b0);
        xor_enable = 1'b0;
        tick();
        check("t1_led_held_idle", led_complete, 1'b1);

        // 2. Shift 0, back-to-back stream
        key = 8'h3C; shift = 3'd0; xor_enable = 1'b1;
        tick();
        check("t2_led_cleared", led_complete, 1'b0);
        for (int i = 0; i < 4; i++) begin
            din = s2_in[i]; din_valid = 1'b1; din_last = (i == 3);
            #1 check($sformatf("t2_ready_%0d", i), din_ready, 1'b1);
            tick();
            check($sformatf("t2_dout_%0d", i), dout, s2_exp[i]);
            check($sformatf("t2_valid_%0d", i), dout_valid, 1'b1);
        end
        din_valid = 1'b0; din_last = 1'b0;
        tick();
        check("t2_byte_count", byte_count, 4);
        check("t2_led", led_complete, 1'b1);
        xor_enable = 1'b0;
        tick();

        // 3+4. Backpressure, and key change after first handshake
        key = 8'hA5; shift = 3'd3; xor_enable = 1'b1;
        tick();
        din = 8'h6D; din_valid = 1'b1; din_last = 1'b0; dout_ready = 1'b0;
        tick();
        key = 8'hFF; shift = 3'd5;
        din = 8'h00; din_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("t3_ready_low_%0d", i), din_ready, 1'b0);
            check($sformatf("t3_dout_held_%0d", i), dout, 8'h40);
            check($sformatf("t3_valid_held_%0d", i), dout_valid, 1'b1);
            tick();
        end
        dout_ready = 1'b1;
        #1 check("t3_ready_release", din_ready, 1'b1);
        tick();
        din_valid = 1'b0; din_last = 1'b0;
        check("t4_latched_key", dout, 8'h2D);
        check("t3_second_valid", dout_valid, 1'b1);
        check("t3_second_last", dout_last, 1'b1);
        check("t3_count_mid", byte_count, 1);
        tick();
        check("t3_byte_count", byte_count, 2);
        check("t3_led", led_complete, 1'b1);
        xor_enable = 1'b0;
        tick();

        // 5a. Abort in RUN with a pending byte
        key = 8'h11; shift = 3'd0; xor_enable = 1'b1;
        tick();
        din = 8'h22; din_valid = 1'b1; din_last = 1'b0; dout_ready = 1'b0;
        tick();
        din_valid = 1'b0;
        check("t5_pending", dout_valid, 1'b1);
        xor_enable = 1'b0;
        tick();
        check("t5_abort_valid", dout_valid, 1'b0);
        check("t5_abort_led", led_complete, 1'b0);
        check("t5_abort_count", byte_count, 0);
        din_valid = 1'b1;
        tick();
        check("t5_idle_ignores_din", dout_valid, 1'b0);
        din_valid = 1'b0;

        // 5b. Reset while in DRAIN
        xor_enable = 1'b1;
        tick();
        din = 8'h33; din_valid = 1'b1; din_last = 1'b1;
        tick();
        din_valid = 1'b0; din_last = 1'b0;
        #1 check("t5_drain_no_ready", din_ready, 1'b0);
        start_reset_n = 1'b0;
        tick();
        check("t5_rst_dout", dout, 8'h00);
        check("t5_rst_valid", dout_valid, 1'b0);
        check("t5_rst_last", dout_last, 1'b0);
        check("t5_rst_count", byte_count, 0);
        check("t5_rst_led", led_complete, 1'b0);
        check("t5_rst_ready", din_ready, 1'b0);
        xor_enable = 1'b0; dout_ready = 1'b1;
        start_reset_n = 1'b1;
        tick();

        // 6. Rolling key (expected values depend on build)
        key = 8'h01; shift = 3'd0; improved_decrypt_enable = 1'b1; xor_enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            din = s6_in[i]; din_valid = 1'b1; din_last = (i == 2);
            tick();
            check($sformatf("t6_dout_%0d", i), dout, s6_exp[i]);
        end
        din_valid = 1'b0; din_last = 1'b0;
        tick();
        check("t6_byte_count", byte_count, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
